// File: rtl/fetch_pkg.sv
// Shared types and address-split helpers for the instruction-fetch stage.
// Every width below is derived from the fetch_unit parameters, so the stage can be resized from its parameter list alone.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   function automatic int byte_off_w(input int instr_w);
      return $clog2(instr_w / 8);
   endfunction

   function automatic int word_off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int index_w(input int cache_lines);
      return $clog2(cache_lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int instr_w,
                                input int line_words, input int cache_lines);
      return addr_w - byte_off_w(instr_w) - word_off_w(line_words) - index_w(cache_lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line store: combinational read port, one synchronous write port.
// Only the valid bits are cleared by reset; tag and data need no reset.
module icache_array
   import fetch_pkg::*;
#(
   parameter int CACHE_LINES = 8,
   parameter int TAG_W       = 10,
   parameter int LINE_W      = 64,
   localparam int IDX_W      = index_w(CACHE_LINES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [LINE_W-1:0] rd_line,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line
);

   logic [CACHE_LINES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
   logic [LINE_W-1:0]      data_q [CACHE_LINES];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage with a direct-mapped icache: 1-cycle hit latency, miss refill via valid/ready request plus single-beat response.
// stall holds the PC and IF/ID but never blocks a refill; FETCH_PERF_CNT_EN adds perf_hits/perf_misses counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int INSTR_W     = 16,
   parameter int LINE_WORDS  = 4,
   parameter int CACHE_LINES = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_W-1:0]             branch_target,
   input  logic                          pc_src,
   input  logic                          stall,
   output logic                          mem_req_valid,
   output logic [ADDR_W-1:0]             mem_req_addr,
   input  logic                          mem_req_ready,
   input  logic                          mem_resp_valid,
   input  logic [LINE_WORDS*INSTR_W-1:0] mem_resp_line,
   output logic                          fetch_valid,
   output logic [INSTR_W-1:0]            fetch_instr,
   output logic [ADDR_W-1:0]             fetch_pc_plus,
   output logic                          hit
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_hits,
   output logic [31:0]                   perf_misses
`endif
);

   localparam int BO_W   = byte_off_w(INSTR_W);
   localparam int WO_W   = word_off_w(LINE_WORDS);
   localparam int IDX_W  = index_w(CACHE_LINES);
   localparam int TAG_W  = tag_w(ADDR_W, INSTR_W, LINE_WORDS, CACHE_LINES);
   localparam int OFF_W  = BO_W + WO_W;
   localparam int LINE_W = LINE_WORDS * INSTR_W;
   localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(INSTR_W / 8);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   fetch_state_t        state, state_nxt;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   pend_pc;
   logic                pend_vld;
   logic [WO_W-1:0]     pc_word;
   logic [IDX_W-1:0]    pc_idx;
   logic [TAG_W-1:0]    pc_tag;
   logic [LINE_W-1:0]   rd_line;
   logic [TAG_W-1:0]    rd_tag;
   logic                rd_valid;
   logic [INSTR_W-1:0]  cur_instr;
   logic                fill_en;
   logic                advance;

   assign pc_word   = pc[BO_W +: WO_W];
   assign pc_idx    = pc[OFF_W +: IDX_W];
   assign pc_tag    = pc[ADDR_W-1 -: TAG_W];
   assign hit       = rd_valid && (rd_tag == pc_tag);
   assign cur_instr = rd_line[pc_word*INSTR_W +: INSTR_W];
   assign advance   = (state == RUN) && !pc_src && !stall && hit;

   icache_array #(
      .CACHE_LINES (CACHE_LINES),
      .TAG_W       (TAG_W),
      .LINE_W      (LINE_W)
   ) u_icache (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (pc_idx),
      .rd_line  (rd_line),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .wr_en    (fill_en),
      .wr_idx   (pc_idx),
      .wr_tag   (pc_tag),
      .wr_line  (mem_resp_line)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // A stalled miss stays in RUN so the held IF/ID contents remain valid.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (!pc_src && !stall && !hit) state_nxt = REQ;
         REQ:     if (mem_req_ready) state_nxt = WAIT;
         WAIT:    if (mem_resp_valid) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      fill_en       = 1'b0;
      case (state)
         REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = pc & LINE_MASK;
         end
         WAIT:    fill_en = mem_resp_valid;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_PC;
         pend_vld      <= 1'b0;
         pend_pc       <= '0;
         fetch_valid   <= 1'b0;
         fetch_instr   <= '0;
         fetch_pc_plus <= '0;
      end else if (state == RUN) begin
         if (pc_src) begin
            pc          <= branch_target;
            fetch_valid <= 1'b0;
         end else if (!stall) begin
            if (hit) begin
               fetch_valid   <= 1'b1;
               fetch_instr   <= cur_instr;
               fetch_pc_plus <= pc + PC_INC;
               pc            <= pc + PC_INC;
            end else begin
               fetch_valid <= 1'b0;
            end
         end
      end else begin
         // The refill always completes; redirects seen meanwhile are parked until RUN.
         fetch_valid <= 1'b0;
         if (pc_src) begin
            pend_vld <= 1'b1;
            pend_pc  <= branch_target;
         end
         if (state == WAIT && mem_resp_valid) begin
            if (pc_src) begin
               pc <= branch_target;
            end else if (pend_vld) begin
               pc <= pend_pc;
            end
            pend_vld <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_hits   <= '0;
         perf_misses <= '0;
      end else begin
         if (advance) perf_hits <= perf_hits + 32'd1;
         if (state == RUN && state_nxt == REQ) perf_misses <= perf_misses + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory word at address a = 16'h1111*(word index+1) + (a & 16'hFFF8).
// The memory responder runs inside tick() with configurable ready and response delays.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [15:0] branch_target;
   logic        pc_src;
   logic        stall;
   logic        mem_req_valid;
   logic [15:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_line;
   logic        fetch_valid;
   logic [15:0] fetch_instr;
   logic [15:0] fetch_pc_plus;
   logic        hit;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ready_delay;
   int          resp_delay;
   int          req_wait;
   int          resp_wait;
   logic        resp_pend;
   logic [15:0] resp_addr;
   logic [15:0] last_req_addr;
   int          req_acc;
   int          r0;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .branch_target  (branch_target),
      .pc_src         (pc_src),
      .stall          (stall),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_line  (mem_resp_line),
      .fetch_valid    (fetch_valid),
      .fetch_instr    (fetch_instr),
      .fetch_pc_plus  (fetch_pc_plus),
      .hit            (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mem_line(input logic [15:0] addr);
      logic [63:0] l;
      for (int w = 0; w < 4; w++) begin
         l[w*16 +: 16] = 16'h1111 * 16'(w + 1) + (addr & 16'hFFF8);
      end
      return l;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then play the memory side for the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      if (resp_pend) begin
         if (resp_wait == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_line  = mem_line(resp_addr);
            resp_pend      = 1'b0;
         end else begin
            resp_wait--;
            mem_resp_valid = 1'b0;
         end
      end else begin
         mem_resp_valid = 1'b0;
      end
      if (mem_req_valid) begin
         if (req_wait >= ready_delay) begin
            mem_req_ready = 1'b1;
            resp_pend     = 1'b1;
            resp_wait     = resp_delay;
            resp_addr     = mem_req_addr;
            last_req_addr = mem_req_addr;
            req_acc++;
            req_wait      = 0;
         end else begin
            req_wait++;
         end
      end else begin
         req_wait = 0;
      end
   endtask

   task automatic redirect(input logic [15:0] t);
      pc_src        = 1'b1;
      branch_target = t;
      tick();
      pc_src        = 1'b0;
   endtask

   task automatic fetch_expect(input string tag, input logic [15:0] ei,
                               input logic [15:0] ep, input int ew);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!fetch_valid && n < 20);
      chk({tag, "_wait"}, 32'(n), 32'(ew));
      chk({tag, "_instr"}, 32'(fetch_instr), 32'(ei));
      chk({tag, "_pcp"}, 32'(fetch_pc_plus), 32'(ep));
   endtask

   logic [15:0] seq_instr [8];

   initial begin
      seq_instr = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                    16'h1119, 16'h222A, 16'h333B, 16'h444C};
      reset = 1'b1; pc_src = 1'b0; stall = 1'b0; branch_target = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_line = '0;
      ready_delay = 0; resp_delay = 0; req_wait = 0; resp_wait = 0;
      resp_pend = 1'b0; resp_addr = '0; last_req_addr = '0; req_acc = 0;

      // Reset state
      tick();
      tick();
      chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst_fetch_instr", 32'(fetch_instr), 32'd0);
      chk("rst_fetch_pc_plus", 32'(fetch_pc_plus), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_req_addr", 32'(mem_req_addr), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      reset = 1'b0;

      // Cold miss on line 0, then four back-to-back hits; then line 1
      fetch_expect("t1_a", 16'h1111, 16'h0002, 4);
      fetch_expect("t1_b", 16'h2222, 16'h0004, 1);
      fetch_expect("t1_c", 16'h3333, 16'h0006, 1);
      fetch_expect("t1_d", 16'h4444, 16'h0008, 1);
      chk("t1_req_addr0", 32'(last_req_addr), 32'h0);
      fetch_expect("t1_e", 16'h1119, 16'h000A, 4);
      chk("t1_req_addr8", 32'(last_req_addr), 32'h8);
      fetch_expect("t1_f", 16'h222A, 16'h000C, 1);
      fetch_expect("t1_g", 16'h333B, 16'h000E, 1);
      fetch_expect("t1_h", 16'h444C, 16'h0010, 1);

      // Jump back to 0: second pass over lines 0 and 1 hits throughout
      redirect(16'h0000);
      chk("t2_bubble", 32'(fetch_valid), 32'd0);
      r0 = req_acc;
      for (int i = 0; i < 8; i++) begin
         chk("t2_hit", 32'(hit), 32'd1);
         fetch_expect("t2_seq", seq_instr[i], 16'(2 * (i + 1)), 1);
      end
      chk("t2_no_req", 32'(req_acc), 32'(r0));

      // Redirect to 0x0040 with stall in the same cycle as a hit
      redirect(16'h0000);
      fetch_expect("t3_pre", 16'h1111, 16'h0002, 1);
      stall = 1'b1;
      redirect(16'h0040);
      stall = 1'b0;
      chk("t3_bubble", 32'(fetch_valid), 32'd0);
      chk("t3_hit", 32'(hit), 32'd0);
      fetch_expect("t3_tgt", 16'h1151, 16'h0042, 4);

      // Slow ready; redirect to 0x0080 parked while in WAIT
      ready_delay = 3;
      resp_delay  = 1;
      redirect(16'h0020);
      chk("t4_miss", 32'(hit), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_req_valid", 32'(mem_req_valid), 32'd1);
         chk("t4_req_addr", 32'(mem_req_addr), 32'h20);
      end
      tick();
      chk("t4_wait_req", 32'(mem_req_valid), 32'd0);
      pc_src        = 1'b1;
      branch_target = 16'h0080;
      tick();
      pc_src        = 1'b0;
      chk("t4_wait_fv", 32'(fetch_valid), 32'd0);
      tick();
      chk("t4_80_miss", 32'(hit), 32'd0);
      ready_delay = 0;
      resp_delay  = 0;
      fetch_expect("t4_tgt", 16'h1191, 16'h0082, 4);
      chk("t4_req_addr80", 32'(last_req_addr), 32'h80);

      // Five stalled cycles hold IF/ID and the PC
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_fv", 32'(fetch_valid), 32'd1);
         chk("t5_instr", 32'(fetch_instr), 32'h1191);
         chk("t5_pcp", 32'(fetch_pc_plus), 32'h82);
      end
      stall = 1'b0;
      fetch_expect("t5_next", 16'h22A2, 16'h0084, 1);

      // Line at 0x0020 filled by the delayed refill
      redirect(16'h0020);
      chk("t5_20_hit", 32'(hit), 32'd1);
      fetch_expect("t5_20", 16'h1131, 16'h0022, 1);

      // 0x0000 and 0x0100 conflict on index 0
      redirect(16'h0000);
      chk("t6_miss0", 32'(hit), 32'd0);
      r0 = req_acc;
      fetch_expect("t6_a", 16'h1111, 16'h0002, 4);
      redirect(16'h0100);
      chk("t6_miss100", 32'(hit), 32'd0);
      fetch_expect("t6_b", 16'h1211, 16'h0102, 4);
      redirect(16'h0000);
      chk("t6_miss0b", 32'(hit), 32'd0);
      fetch_expect("t6_c", 16'h1111, 16'h0002, 4);
      chk("t6_reqs", 32'(req_acc), 32'(r0 + 3));
      chk("t6_req_addr", 32'(last_req_addr), 32'h0);

      // Reset while waiting for a refill; late response must be dropped
      resp_delay = 1;
      redirect(16'h0100);
      tick();
      tick();
      chk("t7_wait_req", 32'(mem_req_valid), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t7_req_valid", 32'(mem_req_valid), 32'd0);
      chk("t7_hit", 32'(hit), 32'd0);
      chk("t7_fv", 32'(fetch_valid), 32'd0);
      chk("t7_pcp", 32'(fetch_pc_plus), 32'd0);
      resp_delay = 0;
      fetch_expect("t7_refetch", 16'h1111, 16'h0002, 4);
      chk("t7_req_addr", 32'(last_req_addr), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
